// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state encodings,
// the per-cycle pipeline control bundle and the default halt-drain depth.
package pipeline_stall_controller_pkg;

    localparam int DEFAULT_DRAIN_CYCLES = 3;
    localparam int DEFAULT_CNT_W        = 32;

    typedef enum logic [1:0] {
        STATE_RUN      = 2'd0,
        STATE_MEM_WAIT = 2'd1,
        STATE_DRAIN    = 2'd2,
        STATE_HALTED   = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_write;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    // Every stage advances, nothing squashed.
    function automatic pipe_ctrl_t ctrl_advance();
        pipe_ctrl_t c;
        c              = '0;
        c.pc_write     = 1'b1;
        c.if_id_write  = 1'b1;
        c.id_ex_write  = 1'b1;
        c.ex_mem_write = 1'b1;
        c.mem_wb_write = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating event counter with asynchronous active-low reset; holds at
// all-ones once reached.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central pipeline sequencer: merges load-use, redirect, data-memory freeze
// and halt requests into PC / pipeline-register enables, flushes and bubbles.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_use_stall,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             id_halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             mem_wb_bubble,
    output logic             is_halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [DRAIN_W-1:0] w_next_drain_cnt;
    logic               r_is_halted;

    logic               w_active;
    logic               w_freeze;
    logic               w_redirect_apply;
    logic               w_lu_apply;
    logic               w_halt_apply;
    logic               w_stall_inc;
    pipe_ctrl_t         w_ctrl;
    pipe_ctrl_t         w_ctrl_out;

    // MEM_WAIT behaves exactly like RUN once memory is ready, so both share one decode.
    assign w_active = (r_state == STATE_RUN) || (r_state == STATE_MEM_WAIT);
    assign w_freeze = (r_state != STATE_HALTED) && dmem_req && !dmem_ready;

    assign w_redirect_apply = w_active && !w_freeze && ex_redirect;
    assign w_lu_apply       = w_active && !w_freeze && !ex_redirect && load_use_stall;
    assign w_halt_apply     = w_active && !w_freeze && !ex_redirect && !load_use_stall
                              && id_halt_req;
    assign w_stall_inc      = w_active && (w_freeze || w_lu_apply);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= STATE_RUN;
            r_drain_cnt <= '0;
            r_is_halted <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_drain_cnt;
            r_is_halted <= (w_next_state == STATE_HALTED);
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_drain_cnt = r_drain_cnt;
        case (r_state)
            STATE_RUN, STATE_MEM_WAIT: begin
                if (w_freeze) begin
                    w_next_state = STATE_MEM_WAIT;
                end else if (w_halt_apply) begin
                    w_next_state     = STATE_DRAIN;
                    w_next_drain_cnt = DRAIN_W'(DRAIN_CYCLES);
                end else begin
                    w_next_state = STATE_RUN;
                end
            end
            STATE_DRAIN: begin
                if (!w_freeze) begin
                    w_next_drain_cnt = r_drain_cnt - DRAIN_W'(1);
                    if (r_drain_cnt == DRAIN_W'(1)) begin
                        w_next_state = STATE_HALTED;
                    end
                end
            end
            STATE_HALTED: begin
                w_next_state = STATE_HALTED;
            end
            default: begin
                w_next_state = STATE_RUN;
            end
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            STATE_RUN, STATE_MEM_WAIT: begin
                if (!w_freeze) begin
                    w_ctrl = ctrl_advance();
                    if (w_redirect_apply) begin
                        w_ctrl.if_id_flush  = 1'b1;
                        w_ctrl.id_ex_bubble = 1'b1;
                    end else if (w_lu_apply) begin
                        w_ctrl.pc_write     = 1'b0;
                        w_ctrl.if_id_write  = 1'b0;
                        w_ctrl.id_ex_bubble = 1'b1;
                    end else if (w_halt_apply) begin
                        w_ctrl.pc_write = 1'b0;
                    end
                end
            end
            STATE_DRAIN: begin
                // Fetch is shut off; only the halt instruction and older keep moving.
                if (!w_freeze) begin
                    w_ctrl              = ctrl_advance();
                    w_ctrl.pc_write     = 1'b0;
                    w_ctrl.if_id_flush  = 1'b1;
                    w_ctrl.id_ex_bubble = 1'b1;
                end
            end
            default: begin
                w_ctrl = '0;
            end
        endcase
    end

    // Outputs collapse to their reset values the instant reset_n falls.
    assign w_ctrl_out    = reset_n ? w_ctrl : '0;
    assign pc_write      = w_ctrl_out.pc_write;
    assign if_id_write   = w_ctrl_out.if_id_write;
    assign if_id_flush   = w_ctrl_out.if_id_flush;
    assign id_ex_write   = w_ctrl_out.id_ex_write;
    assign id_ex_bubble  = w_ctrl_out.id_ex_bubble;
    assign ex_mem_write  = w_ctrl_out.ex_mem_write;
    assign mem_wb_write  = w_ctrl_out.mem_wb_write;
    assign mem_wb_bubble = w_ctrl_out.mem_wb_bubble;
    assign is_halted     = r_is_halted;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_stall_inc),
        .count   (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_redirect_apply),
        .count   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: hand-computed control vectors,
// counters, drain timing and asynchronous reset behaviour.
module tb_pipeline_stall_controller;

    localparam int CNT_W = 32;

    // Control vector order: pc, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, memwb_w, memwb_bub
    localparam logic [7:0] C_RESET  = 8'b0000_0000;
    localparam logic [7:0] C_RUN    = 8'b1101_0110;
    localparam logic [7:0] C_LU     = 8'b0001_1110;
    localparam logic [7:0] C_REDIR  = 8'b1111_1110;
    localparam logic [7:0] C_HALTRQ = 8'b0101_0110;
    localparam logic [7:0] C_DRAIN  = 8'b0111_1110;
    localparam logic [7:0] C_FROZEN = 8'b0000_0000;

    logic             clk;
    logic             reset_n;
    logic             load_use_stall;
    logic             ex_redirect;
    logic             dmem_req;
    logic             dmem_ready;
    logic             id_halt_req;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_bubble;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic             mem_wb_bubble;
    logic             is_halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [7:0]       ctl;

    int n_total;
    int n_fail;

    pipeline_stall_controller #(
        .DRAIN_CYCLES (3),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .load_use_stall (load_use_stall),
        .ex_redirect    (ex_redirect),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .id_halt_req    (id_halt_req),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_write    (id_ex_write),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_write   (ex_mem_write),
        .mem_wb_write   (mem_wb_write),
        .mem_wb_bubble  (mem_wb_bubble),
        .is_halted      (is_halted),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write,
                  id_ex_bubble, ex_mem_write, mem_wb_write, mem_wb_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        load_use_stall = 1'b0;
        ex_redirect    = 1'b0;
        dmem_req       = 1'b0;
        dmem_ready     = 1'b0;
        id_halt_req    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        n_total = 0;
        n_fail  = 0;
        clear_inputs();
        reset_n = 1'b0;
        #2;
        chk("reset_ctl", 32'(ctl), 32'(C_RESET));
        chk("reset_halted", 32'(is_halted), 32'd0);
        tick();
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_flush_cnt", flush_cnt, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("run_idle_ctl", 32'(ctl), 32'(C_RUN));

        // Load-use stall for a single cycle
        load_use_stall = 1'b1;
        #1;
        chk("lu_ctl", 32'(ctl), 32'(C_LU));
        tick();
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        load_use_stall = 1'b0;
        #1;
        chk("lu_after_ctl", 32'(ctl), 32'(C_RUN));

        // Redirect and load-use together: redirect wins
        ex_redirect    = 1'b1;
        load_use_stall = 1'b1;
        #1;
        chk("redir_lu_ctl", 32'(ctl), 32'(C_REDIR));
        tick();
        chk("redir_flush_cnt", flush_cnt, 32'd1);
        chk("redir_stall_cnt", stall_cnt, 32'd1);
        clear_inputs();

        // Data memory freeze for 3 cycles, then ready
        dmem_req   = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("freeze_ctl", 32'(ctl), 32'(C_FROZEN));
            tick();
            chk("freeze_state", 32'(dut.r_state), 32'd1);
        end
        chk("freeze_stall_cnt", stall_cnt, 32'd4);
        dmem_ready = 1'b1;
        #1;
        chk("ready_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        chk("ready_state", 32'(dut.r_state), 32'd0);
        chk("ready_stall_cnt", stall_cnt, 32'd4);
        clear_inputs();

        // Halt request coincident with redirect: redirect applied, no drain
        id_halt_req = 1'b1;
        ex_redirect = 1'b1;
        #1;
        chk("halt_redir_ctl", 32'(ctl), 32'(C_REDIR));
        tick();
        chk("halt_redir_state", 32'(dut.r_state), 32'd0);
        chk("halt_redir_flush_cnt", flush_cnt, 32'd2);
        chk("halt_redir_halted", 32'(is_halted), 32'd0);
        clear_inputs();

        // Halt request, plain drain of 3 cycles
        id_halt_req = 1'b1;
        #1;
        chk("halt_req_ctl", 32'(ctl), 32'(C_HALTRQ));
        tick();
        clear_inputs();
        ex_redirect    = 1'b1;
        load_use_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain_ctl", 32'(ctl), 32'(C_DRAIN));
            chk("drain_halted", 32'(is_halted), 32'd0);
            tick();
        end
        chk("halted_flag", 32'(is_halted), 32'd1);
        chk("halted_ctl", 32'(ctl), 32'(C_RESET));
        chk("drain_flush_cnt", flush_cnt, 32'd2);
        chk("drain_stall_cnt", stall_cnt, 32'd4);
        dmem_req = 1'b1;
        tick();
        tick();
        chk("halted_sticky", 32'(is_halted), 32'd1);
        chk("halted_ctl_frozen_req", 32'(ctl), 32'(C_RESET));
        chk("halted_stall_cnt", stall_cnt, 32'd4);
        chk("halted_flush_cnt", flush_cnt, 32'd2);

        // Drain with one freeze cycle inserted: halt one cycle later
        do_reset();
        id_halt_req = 1'b1;
        tick();
        clear_inputs();
        #1;
        chk("drainf_ctl1", 32'(ctl), 32'(C_DRAIN));
        tick();
        dmem_req = 1'b1;
        #1;
        chk("drainf_frozen_ctl", 32'(ctl), 32'(C_FROZEN));
        tick();
        clear_inputs();
        chk("drainf_stall_cnt", stall_cnt, 32'd0);
        #1;
        chk("drainf_ctl3", 32'(ctl), 32'(C_DRAIN));
        tick();
        chk("drainf_not_yet", 32'(is_halted), 32'd0);
        tick();
        chk("drainf_halted", 32'(is_halted), 32'd1);

        // Asynchronous reset in the middle of a drain
        do_reset();
        load_use_stall = 1'b1;
        tick();
        load_use_stall = 1'b0;
        chk("pre_rst_stall_cnt", stall_cnt, 32'd1);
        id_halt_req = 1'b1;
        tick();
        clear_inputs();
        #1;
        chk("pre_rst_drain_ctl", 32'(ctl), 32'(C_DRAIN));
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_ctl", 32'(ctl), 32'(C_RESET));
        chk("async_rst_stall_cnt", stall_cnt, 32'd0);
        chk("async_rst_state", 32'(dut.r_state), 32'd0);
        chk("async_rst_halted", 32'(is_halted), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        chk("post_rst_state", 32'(dut.r_state), 32'd0);
        chk("post_rst_flush_cnt", flush_cnt, 32'd0);
        chk("post_rst_stall_cnt", stall_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central sequencer for the 5-stage RISC-V pipeline. It merges the load-use stall flag, the EX-stage branch/jump redirect, the data-memory ready handshake and the ID-stage halt (ecall) request. From these it drives every PC and pipeline-register write-enable, flush and bubble control. It owns the halt-drain sequence and the stall/flush performance counters, and sits beside the hazard detector, feeding the cpu top-level pipeline registers.

Parameters:
DRAIN_CYCLES, 3, cycles after halt acceptance until is_halted (halt instr traverses EX, MEM, WB)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
load_use_stall  in  1  load-use hazard flag from hazard detection
ex_redirect  in  1  EX resolved taken branch/jump mispredict; pc must load redirect target
dmem_req  in  1  MEM stage holds a valid load/store
dmem_ready  in  1  data memory completes the request this cycle
id_halt_req  in  1  ID holds ecall with x17==10
pc_write  out  1  PC register write enable
if_id_write  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_write  out  1  ID/EX write enable
id_ex_bubble  out  1  ID/EX loads a NOP (control zeroed)
ex_mem_write  out  1  EX/MEM write enable
mem_wb_write  out  1  MEM/WB write enable
mem_wb_bubble  out  1  MEM/WB loads a NOP (no regfile write)
is_halted  out  1  registered; pipeline fully drained
stall_cnt  out  CNT_W  cycles lost to stall or freeze
flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Clock domain: one clock. Reset is asynchronous and active-low. While reset_n=0: state=RUN, drain_cnt=0, is_halted=0, counters=0, all write enables 0, flush/bubble 0.
- States: RUN, MEM_WAIT, DRAIN, HALTED. State held in 2-bit register; drain_cnt is a clog2(DRAIN_CYCLES+1)-bit down counter.
- freeze = dmem_req & ~dmem_ready, evaluated combinationally in any state except HALTED.
- freeze=1: all write enables 0, all flush/bubble 0 (whole pipeline held). Redirect, load-use and halt inputs are ignored that cycle; they remain valid because their stages are held.
- RUN, unfrozen, priority redirect > load-use > halt:
  - redirect: pc_write=1, if_id_flush=1, id_ex_bubble=1, other writes 1. Squashes any load-use stall or halt in the same cycle.
  - load_use_stall: pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem/mem_wb writes 1.
  - id_halt_req: all writes 1, pc_write=0. Next state DRAIN, drain_cnt=DRAIN_CYCLES.
  - none: all writes 1, no flush/bubble.
- RUN to MEM_WAIT when freeze=1. MEM_WAIT stays while freeze=1. On dmem_ready=1, outputs for that cycle follow the RUN rules and next state is RUN; zero extra penalty after ready.
- DRAIN: pc_write=0, if_id_flush=1, id_ex_bubble=1. Downstream writes are 1 unless frozen. drain_cnt decrements only on unfrozen cycles. On the unfrozen cycle where drain_cnt==1, next state is HALTED. ex_redirect, load_use_stall and id_halt_req are ignored in DRAIN.
- HALTED: is_halted=1 registered (asserted first cycle in HALTED). pc_write and if_id_write 0. id_ex/ex_mem/mem_wb writes 0. Sticky until reset. dmem_req is ignored.
- stall_cnt: +1 per cycle with (freeze or load_use stall applied) in RUN/MEM_WAIT.
- flush_cnt: +1 per applied redirect.
- Both counters saturate at all-ones and do not count in HALTED.
- Reset asserted mid-DRAIN or mid-MEM_WAIT returns immediately to RUN with outputs at reset values.

Decomposition:
- Shared package/header (beside opcodes): state encodings (STATE_RUN=0, STATE_MEM_WAIT=1, STATE_DRAIN=2, STATE_HALTED=3) and default DRAIN_CYCLES.
- One natural sub-module: sat_counter (CNT_W, inc, clk, reset_n), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
1. Load-use: load_use_stall=1 one cycle in RUN. Expect pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt 0→1; next cycle all writes 1.
2. Redirect plus load-use in the same cycle. Expect pc_write=1, if_id_flush=1, id_ex_bubble=1; flush_cnt=1; stall_cnt unchanged.
3. dmem_req=1, dmem_ready=0 for 3 cycles then ready. Expect all enables 0 for 3 cycles; state MEM_WAIT; stall_cnt=3; ready cycle all writes 1; state RUN next.
4. id_halt_req=1 with DRAIN_CYCLES=3. Expect DRAIN for 3 cycles with pc_write=0 and if_id_flush=1; is_halted=1 exactly 4 cycles after the request cycle. Repeat with one freeze cycle inserted mid-drain: is_halted is delayed by exactly 1 cycle.
5. id_halt_req and ex_redirect in the same cycle. Expect the redirect to be applied and state to remain RUN; is_halted stays 0.
6. Reset asserted (reset_n=0) asynchronously mid-DRAIN. Expect outputs at reset values immediately without a clock edge; after release, state RUN and counters 0.
